// File: rtl/keypad_matrix_scanner_if.sv
// rtl/keypad_matrix_scanner_if.sv - key matrix drive/sense and debounced key event signals
interface keypad_matrix_scanner_if;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;
    logic       key_multi;

    modport master (
        output key_col,
        input  key_row,
        output key_valid,
        output key_code,
        output key_down,
        output key_multi
    );

    modport slave (
        input  key_col,
        output key_row,
        input  key_valid,
        input  key_code,
        input  key_down,
        input  key_multi
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - 4x4 key matrix column scanner with frame-level debounce
module keypad_matrix_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    keypad_matrix_scanner_if.master         bus
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD,
        RELEASE
    } state_t;

    logic [3:0]    r_key_col;
    logic [1:0]    r_col_idx;
    logic [DW-1:0] r_dwell;
    logic [3:0]    r_row_s1;
    logic [3:0]    r_row_s2;
    logic [15:0]   r_frame;
    logic          r_frame_done;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic          r_key_valid;
    logic [3:0]    r_key_code;
    logic          r_key_down;
    logic          r_key_multi;

    logic [4:0]    w_count;
    logic [3:0]    w_idx;
    logic [3:0]    w_code;
    logic          w_none;
    logic          w_single;
    logic          w_multi;
    logic          w_same;

    assign bus.key_col   = r_key_col;
    assign bus.key_valid = r_key_valid;
    assign bus.key_code  = r_key_code;
    assign bus.key_down  = r_key_down;
    assign bus.key_multi = r_key_multi;

    // Rows are asynchronous; the dwell of >= 4 cycles lets the synchronizer settle per column.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_col    <= 4'b1110;
            r_col_idx    <= 2'd0;
            r_dwell      <= '0;
            r_row_s1     <= 4'b1111;
            r_row_s2     <= 4'b1111;
            r_frame      <= 16'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_row_s1     <= bus.key_row;
            r_row_s2     <= r_row_s1;
            r_frame_done <= 1'b0;
            if (r_dwell == DW'(SCAN_DIV - 1)) begin
                r_frame[{r_col_idx, 2'b00} +: 4] <= ~r_row_s2;
                r_dwell      <= '0;
                r_col_idx    <= r_col_idx + 2'd1;
                r_key_col    <= ~(4'b0001 << (r_col_idx + 2'd1));
                r_frame_done <= (r_col_idx == 2'd3);
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    // Frame bit index is col*4+row; key code is {row, col}.
    always_comb begin
        w_count = 5'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_frame[i]) begin
                w_count = w_count + 5'd1;
                w_idx   = 4'(i);
            end
        end
        w_code   = {w_idx[1:0], w_idx[3:2]};
        w_none   = (w_count == 5'd0);
        w_single = (w_count == 5'd1);
        w_multi  = (w_count > 5'd1);
        w_same   = w_single && (w_code == r_cand);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cand      <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_down  <= 1'b0;
            r_key_multi <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_frame_done) begin
                r_key_multi <= w_multi;
                case (r_state)
                    IDLE: begin
                        if (w_single) begin
                            r_state <= CONFIRM;
                            r_cand  <= w_code;
                            r_cnt   <= CW'(1);
                        end
                    end
                    CONFIRM: begin
                        if (w_same) begin
                            r_cnt <= r_cnt + CW'(1);
                            if (int'(r_cnt) + 1 == DEBOUNCE) begin
                                r_state     <= HELD;
                                r_key_code  <= r_cand;
                                r_key_valid <= 1'b1;
                                r_key_down  <= 1'b1;
                            end
                        end else if (w_single) begin
                            r_cand <= w_code;
                            r_cnt  <= CW'(1);
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    HELD: begin
                        if (!w_same) begin
                            r_state <= RELEASE;
                            r_cnt   <= w_none ? CW'(1) : '0;
                        end
                    end
                    RELEASE: begin
                        if (w_none) begin
                            if (int'(r_cnt) + 1 == DEBOUNCE) begin
                                r_state    <= IDLE;
                                r_cnt      <= '0;
                                r_key_down <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end else if (w_same) begin
                            // Contact bounced back to the held key: resume without a new event.
                            r_state <= HELD;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    typedef struct {
        logic [3:0] col;
        logic       valid;
        logic       down;
        logic       multi;
        logic [3:0] code;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] pressed;
    logic [3:0]  row_model;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    int          n_cmp;
    int          n_bad;
    int          pulse_cnt;
    vec_t        vecs[20];

    keypad_matrix_scanner_if kp ();

    keypad_matrix_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pressed[r*4+c]: row r pulled low while column c is driven low
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_model[r] = ~|(pressed[r*4 +: 4] & ~kp.key_col);
        end
    end
    assign kp.key_row = row_model;

    always @(negedge clk) begin
        if (!reset && kp.key_valid === 1'b1) begin
            pulse_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse actual code=%0d required no pulse", kp.key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (kp.key_code !== mon_exp || kp.key_down !== 1'b1) begin
                    n_bad++;
                    $display("FAIL pulse_code actual code=%0d down=%0b required code=%0d down=1",
                             kp.key_code, kp.key_down, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s actual=%0d required %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic align();
        int n;
        n = 0;
        while (kp.key_col !== 4'b0111 && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (kp.key_col !== 4'b1110 && n < 128) begin
            @(negedge clk);
            n++;
        end
        if (n >= 128) begin
            n_cmp++;
            n_bad++;
            $display("FAIL align_timeout actual=%0d cycles required <128", n);
        end
    endtask

    task automatic wait_pulse(input int budget, output int el);
        el = 0;
        while (el <= budget) begin
            @(negedge clk);
            el++;
            if (kp.key_valid === 1'b1) break;
        end
    endtask

    task automatic wait_down_low(input int budget, output int el);
        el = 0;
        while (el <= budget) begin
            @(negedge clk);
            el++;
            if (kp.key_down === 1'b0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int el;
        int p0;
        logic down_seen;

        for (int k = 0; k < 20; k++) begin
            vecs[k].col   = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            vecs[k].valid = 1'b0;
            vecs[k].down  = 1'b0;
            vecs[k].multi = 1'b0;
            vecs[k].code  = 4'd0;
        end

        n_cmp     = 0;
        n_bad     = 0;
        pulse_cnt = 0;
        pressed   = 16'd0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);

        // 1: reset state and idle column walk
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("idle_vec%0d", k),
                  {kp.key_col, kp.key_valid, kp.key_down, kp.key_multi, kp.key_code},
                  {vecs[k].col, vecs[k].valid, vecs[k].down, vecs[k].multi, vecs[k].code});
        end

        // 2: steady press of (row2,col1)
        align();
        pressed[2*4+1] = 1'b1;
        exp_q.push_back(4'd9);
        wait_pulse(64, el);
        check_range("press_latency", el, 3 * FRAME, 4 * FRAME);
        check("press_code", kp.key_code, 4'd9);
        check("press_down", kp.key_down, 1'b1);
        #1;
        p0 = pulse_cnt;
        repeat (10 * FRAME) @(negedge clk);
        #1;
        check("held_no_repeat", pulse_cnt, p0);
        check("held_down", kp.key_down, 1'b1);

        // 4: release
        align();
        pressed = 16'd0;
        wait_down_low(64, el);
        check_range("release_latency", el, 2 * FRAME + 1, 4 * FRAME);
        check("release_code_kept", kp.key_code, 4'd9);
        #1;
        check("release_no_pulse", pulse_cnt, p0);

        // 3: press toggling every frame
        align();
        down_seen = 1'b0;
        for (int f = 0; f < 12; f++) begin
            pressed[2*4+1] = (f % 2 == 0);
            repeat (FRAME) begin
                @(negedge clk);
                if (kp.key_down !== 1'b0) down_seen = 1'b1;
            end
        end
        pressed = 16'd0;
        repeat (2 * FRAME) @(negedge clk);
        #1;
        check("toggle_no_down", down_seen, 1'b0);
        check("toggle_no_pulse", pulse_cnt, p0);

        // 5: two keys, then one released
        align();
        pressed[0]  = 1'b1;
        pressed[15] = 1'b1;
        repeat (4 * FRAME) @(negedge clk);
        #1;
        check("multi_level", kp.key_multi, 1'b1);
        check("multi_no_pulse", pulse_cnt, p0);
        align();
        pressed[0] = 1'b0;
        exp_q.push_back(4'd15);
        wait_pulse(64, el);
        check_range("multi_to_single_latency", el, 3 * FRAME, 4 * FRAME);
        check("single_multi_low", kp.key_multi, 1'b0);
        check("single_code", kp.key_code, 4'd15);
        pressed = 16'd0;
        wait_down_low(80, el);
        check_range("multi_release", el, 1, 80);

        // 6: reset mid-CONFIRM after two matching frames
        align();
        pressed[1*4+2] = 1'b1;
        repeat (2 * FRAME + 8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_outputs",
              {kp.key_col, kp.key_valid, kp.key_down, kp.key_multi, kp.key_code},
              {4'b1110, 1'b0, 1'b0, 1'b0, 4'd0});
        reset = 1'b0;
        exp_q.push_back(4'd6);
        wait_pulse(64, el);
        check_range("post_reset_latency", el, 3 * FRAME, 4 * FRAME);
        pressed = 16'd0;
        repeat (4 * FRAME) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Scans the board's 4x4 key matrix and debounces it.
- Delivers one clean event per key press to the board-test logic, which otherwise consumes raw key_col/key_row.
- Sits directly upstream of the test core: drives the matrix columns and reads the rows.
- Outputs a one-cycle press pulse with a 4-bit key code, plus held and multi-key status levels.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled; legal range >= 4.
DEBOUNCE, 4, consecutive identical full-matrix frames needed to accept a press or a release; legal range >= 2.

Ports:
clk  input  1  system clock; all logic rises on it
reset  input  1  synchronous, active-high reset
key_col  output  4  column drive, active-low, exactly one bit low at a time
key_row  input  4  row sense, active-low, asynchronous, externally pulled up
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  code of the last accepted key = {row_idx[1:0], col_idx[1:0]}; held between presses
key_down  output  1  level, high while the accepted key is held (press accepted to release accepted)
key_multi  output  1  level, high when the latest frame saw more than one key pressed

Behaviour:
- Reset values:
  - key_col=4'b1110; col_idx=0; dwell=0.
  - Row synchronizer both stages = 4'b1111.
  - Frame register = 0; FSM=IDLE; debounce cnt=0.
  - key_valid=0; key_code=0; key_down=0; key_multi=0.
- key_row passes through a 2-flop synchronizer. SCAN_DIV>=4 guarantees the synchronized rows are settled before sampling.
- Scanning:
  - dwell counts 0..SCAN_DIV-1; key_col = ~(4'b0001 << col_idx).
  - At dwell==SCAN_DIV-1: store ~synced_rows into frame[col_idx*4 +: 4] (1 = pressed), reset dwell, advance col_idx 3->0 with wrap.
- frame_done:
  - Internal one-cycle strobe on the cycle after column 3 is stored. Frame period = 4*SCAN_DIV cycles.
  - Classification of the 16-bit frame: NONE (all 0), SINGLE (exactly one bit set, code derived from that bit), MULTI (two or more bits set).
  - key_multi is updated from the classification on every frame_done.
- Debounce FSM (transitions evaluated only on frame_done):
  - IDLE:
    - SINGLE -> CONFIRM, cand=code, cnt=1.
    - NONE or MULTI -> stay.
  - CONFIRM:
    - SINGLE with code==cand -> cnt+1. When cnt+1==DEBOUNCE: go to HELD, key_code<=cand, key_valid=1 for exactly one cycle, key_down<=1.
    - SINGLE with a different code -> stay, cand=new code, cnt=1.
    - NONE or MULTI -> IDLE, cnt=0.
  - HELD:
    - SINGLE with code==cand -> stay.
    - Anything else -> RELEASE. cnt=1 if NONE, else cnt=0.
  - RELEASE:
    - NONE -> cnt+1. When cnt+1==DEBOUNCE: go to IDLE, key_down<=0.
    - SINGLE with code==cand -> HELD (bounce), no new pulse.
    - Other SINGLE or MULTI -> stay, cnt=0.
- Boundary rules:
  - A second key pressed while one is held is never reported until a full release.
  - MULTI never produces key_valid.
  - Press latency from stable contact: at most DEBOUNCE+1 frames.
  - key_valid never asserts twice for one press, and never on release.
- Reset asserted at any point, including mid-CONFIRM or mid-RELEASE, returns everything to reset values on the next edge with no pulse emitted. Scanning restarts at column 0.

Test Plan:
Bench setup for all scenarios: SCAN_DIV=4, DEBOUNCE=3, frame = 16 cycles. Matrix model: key_row[r]=0 iff key_col[c]==0 and key (r,c) is pressed.
1. Reset then idle -> key_col=1110 for 4 cycles, then 1101, 1011, 0111, then wraps to 1110 at cycle 16; all outputs stay 0 throughout.
2. Press (row2,col1) held steadily -> exactly one key_valid pulse within 64 cycles, with key_code=4'd9 and key_down=1; no further pulse over 10 more frames.
3. Press toggling every frame (pressed 1 frame, released 1 frame) for 12 frames -> key_valid stays 0 and key_down stays 0.
4. Release after scenario 2 -> key_down falls 3 frames after release (within 64 cycles); no pulse; key_code stays 9.
5. Press (0,0) and (3,3) together -> key_multi=1, no key_valid. Then release (0,0) -> key_multi=0 and one pulse with key_code=4'd15.
6. Assert reset for 1 cycle while in CONFIRM after 2 matching frames -> no pulse, key_col=1110 on the next cycle; with the key still held, the pulse arrives only after 3 fresh frames.
